// File: rtl/serializer_param.sv
// Parallel-to-serial converter with a one-word holding buffer and idle/comma fill.
// Every slot is exactly BITS cycles; empty slots carry IDLE_WORD so the line never stalls.
module serializer_param #(
    parameter int unsigned     BITS      = 8,
    parameter bit              MSB_FIRST = 1'b1,
    parameter logic [BITS-1:0] IDLE_WORD = BITS'(8'hBC)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [BITS-1:0] data,
    input  logic            enb,
    output logic            ready,
    output logic            out,
    output logic            DK,
    output logic            sof
);

    localparam int unsigned     CW   = $clog2(BITS);
    localparam logic [CW-1:0]   LAST = CW'(BITS - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_DATA = 1'b1
    } state_e;

    // Handshake: a word on data is taken at the next rising edge when enb && ready
    // are both high in the same cycle; data is ignored whenever ready is low.

    state_e          state_q, state_d;
    logic [BITS-1:0] shifter_q, shifter_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BITS-1:0] hbuf_q, hbuf_d;
    logic            hvalid_q, hvalid_d;
    logic            out_q, out_d;
    logic            sof_q, sof_d;

    logic            last;
    logic [BITS-1:0] src_word;
    logic            src_avail;

    assign last  = (cnt_q == LAST);
    assign ready = !hvalid_q || last;
    assign out   = out_q;
    assign sof   = sof_q;
    assign DK    = (state_q == S_DATA);

    // Slot source priority: buffered word, then cut-through input, then idle fill.
    always_comb begin
        src_word  = IDLE_WORD;
        src_avail = 1'b0;
        if (hvalid_q) begin
            src_word  = hbuf_q;
            src_avail = 1'b1;
        end else if (enb) begin
            src_word  = data;
            src_avail = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        shifter_d = shifter_q;
        cnt_d     = cnt_q;
        hbuf_d    = hbuf_q;
        hvalid_d  = hvalid_q;
        out_d     = out_q;
        sof_d     = 1'b0;

        if (last) begin
            shifter_d = src_word;
            out_d     = MSB_FIRST ? src_word[BITS-1] : src_word[0];
            sof_d     = 1'b1;
            state_d   = src_avail ? S_DATA : S_IDLE;
            cnt_d     = '0;
            if (hvalid_q) begin
                hvalid_d = enb;
                if (enb) begin
                    hbuf_d = data;
                end
            end
        end else begin
            // The shifter walks the slot word so the next bit is always at a fixed index.
            if (MSB_FIRST) begin
                out_d     = shifter_q[BITS-2];
                shifter_d = shifter_q << 1;
            end else begin
                out_d     = shifter_q[1];
                shifter_d = shifter_q >> 1;
            end
            cnt_d = cnt_q + CW'(1);
            if (enb && !hvalid_q) begin
                hbuf_d   = data;
                hvalid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            shifter_q <= '0;
            cnt_q     <= LAST;
            hbuf_q    <= '0;
            hvalid_q  <= 1'b0;
            out_q     <= 1'b0;
            sof_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shifter_q <= shifter_d;
            cnt_q     <= cnt_d;
            hbuf_q    <= hbuf_d;
            hvalid_q  <= hvalid_d;
            out_q     <= out_d;
            sof_q     <= sof_d;
        end
    end

endmodule

// File: tb/tb_serializer_param.sv
// Bench for serializer_param: an 8-bit MSB-first instance and a 10-bit LSB-first instance,
// each line checked bit-by-bit against an expected queue of {sof, DK, out}.
module tb_serializer_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, a_enb, a_ready, a_out, a_dk, a_sof;
    logic [7:0] a_data;
    logic       rst_b, b_enb, b_ready, b_out, b_dk, b_sof;
    logic [9:0] b_data;

    serializer_param #(.BITS(8), .MSB_FIRST(1'b1), .IDLE_WORD(8'hBC)) u_a (
        .clk(clk), .rst(rst_a), .data(a_data), .enb(a_enb),
        .ready(a_ready), .out(a_out), .DK(a_dk), .sof(a_sof)
    );

    serializer_param #(.BITS(10), .MSB_FIRST(1'b0), .IDLE_WORD(10'h0BC)) u_b (
        .clk(clk), .rst(rst_b), .data(b_data), .enb(b_enb),
        .ready(b_ready), .out(b_out), .DK(b_dk), .sof(b_sof)
    );

    int errors = 0;
    int checks = 0;

    logic [2:0] exp_a_q[$];
    logic [2:0] exp_b_q[$];
    bit         mon_a = 1'b0;
    bit         mon_b = 1'b0;
    int         idx_a = 0;
    int         idx_b = 0;

    logic [7:0] stream_w [3] = '{8'h01, 8'h80, 8'hFF};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Expected line entries {sof, DK, out}, first n bits of a slot, MSB first.
    task automatic push_a(input logic [7:0] w, input logic dk, input int n);
        for (int i = 0; i < n; i++) exp_a_q.push_back({(i == 0), dk, w[7-i]});
    endtask

    // Same for the 10-bit LSB-first line.
    task automatic push_b(input logic [9:0] w, input logic dk, input int n);
        for (int i = 0; i < n; i++) exp_b_q.push_back({(i == 0), dk, w[i]});
    endtask

    // Monitors: every sampled line bit must match the head of its expected queue.
    always @(negedge clk) begin
        if (mon_a) begin
            checks++;
            if (exp_a_q.size() == 0) begin
                errors++;
                $display("FAIL a_line_underflow got=%b%b%b exp=none at %0t", a_sof, a_dk, a_out, $time);
            end else begin
                logic [2:0] e;
                e = exp_a_q.pop_front();
                if ({a_sof, a_dk, a_out} !== e) begin
                    errors++;
                    $display("FAIL a_line bit=%0d got sof/dk/out=%b%b%b exp=%b at %0t",
                             idx_a, a_sof, a_dk, a_out, e, $time);
                end
            end
            idx_a++;
        end
    end

    always @(negedge clk) begin
        if (mon_b) begin
            checks++;
            if (exp_b_q.size() == 0) begin
                errors++;
                $display("FAIL b_line_underflow got=%b%b%b exp=none at %0t", b_sof, b_dk, b_out, $time);
            end else begin
                logic [2:0] e;
                e = exp_b_q.pop_front();
                if ({b_sof, b_dk, b_out} !== e) begin
                    errors++;
                    $display("FAIL b_line bit=%0d got sof/dk/out=%b%b%b exp=%b at %0t",
                             idx_b, b_sof, b_dk, b_out, e, $time);
                end
            end
            idx_b++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wi;
        int guard;
        int lows;
        logic r;

        rst_a = 1'b0; rst_b = 1'b0;
        a_enb = 1'b0; a_data = '0; b_enb = 1'b0; b_data = '0;
        #2;
        rst_a = 1'b1; rst_b = 1'b1;
        tick(); tick();

        check("a_rst_out",   32'(a_out),   32'd0);
        check("a_rst_dk",    32'(a_dk),    32'd0);
        check("a_rst_sof",   32'(a_sof),   32'd0);
        check("a_rst_ready", 32'(a_ready), 32'd1);
        check("b_rst_ready", 32'(b_ready), 32'd1);

        // Idle fill after release: two 0xBC slots, DK low.
        rst_a = 1'b0;
        tick();                       // edge 1 (boundary)
        mon_a = 1'b1;
        push_a(8'hBC, 1'b0, 8);
        push_a(8'hBC, 1'b0, 8);
        repeat (15) tick();           // after edge 16

        // Single word on a boundary cycle, then idle resumes.
        a_data = 8'hA5; a_enb = 1'b1;
        check("a_ready_idle", 32'(a_ready), 32'd1);
        push_a(8'hA5, 1'b1, 8);
        tick();                       // edge 17 accepts
        a_enb = 1'b0;
        repeat (7) tick();            // after edge 24

        // Back-to-back stream, advancing on ready.
        push_a(8'h01, 1'b1, 8);
        push_a(8'h80, 1'b1, 8);
        push_a(8'hFF, 1'b1, 8);
        push_a(8'hBC, 1'b0, 8);
        wi = 0; guard = 0;
        while (wi < 3 && guard < 64) begin
            a_enb = 1'b1; a_data = stream_w[wi];
            r = a_ready;
            tick();
            guard++;
            if (r) wi++;
        end
        a_enb = 1'b0;
        check("a_stream_accepted", 32'(wi), 32'd3);

        lows = 0;
        for (int i = 0; i < 8; i++) begin
            if (!a_ready) lows++;
            tick();
        end
        check("a_ready_low_per_slot", 32'(lows), 32'd7);   // now after edge 41

        // Mid-slot acceptance at counter 3 of the idle slot starting at edge 49.
        repeat (11) tick();           // after edge 52
        a_data = 8'h3C; a_enb = 1'b1;
        check("a_ready_midslot", 32'(a_ready), 32'd1);
        push_a(8'h3C, 1'b1, 8);
        tick();                       // edge 53 buffers 0x3C
        a_data = 8'h5A;
        for (int k = 0; k < 3; k++) begin
            check("a_ready_blocked", 32'(a_ready), 32'd0);
            tick();
        end
        check("a_ready_at_boundary", 32'(a_ready), 32'd1);
        push_a(8'h5A, 1'b1, 4);       // reset lands on bit 4 of this slot
        tick();                       // edge 57: 0x3C out, 0x5A into buffer
        a_enb = 1'b0;
        repeat (8) tick();            // after edge 65
        a_data = 8'hC3; a_enb = 1'b1;
        tick();                       // edge 66 buffers 0xC3
        a_enb = 1'b0;
        repeat (3) tick();            // after edge 69, bit 4 of 0x5A on the line
        mon_a = 1'b0;
        check("a_queue_before_rst", 32'(exp_a_q.size()), 32'd0);
        check("a_dk_before_rst",  32'(a_dk),  32'd1);
        rst_a = 1'b1;
        #1;
        check("a_async_rst_out",   32'(a_out),   32'd0);
        check("a_async_rst_dk",    32'(a_dk),    32'd0);
        check("a_async_rst_sof",   32'(a_sof),   32'd0);
        check("a_async_rst_ready", 32'(a_ready), 32'd1);
        tick(); tick();
        rst_a = 1'b0;
        tick();
        mon_a = 1'b1;
        push_a(8'hBC, 1'b0, 8);       // buffered 0xC3 must never appear
        push_a(8'hBC, 1'b0, 8);
        for (int g = 0; g < 40 && exp_a_q.size() != 0; g++) tick();
        mon_a = 1'b0;
        check("a_queue_drained", 32'(exp_a_q.size()), 32'd0);

        // 10-bit LSB-first instance, word 10'h001.
        rst_b = 1'b0;
        tick();                       // edge 1 (boundary)
        mon_b = 1'b1;
        push_b(10'h0BC, 1'b0, 10);
        repeat (9) tick();            // after edge 10
        b_data = 10'h001; b_enb = 1'b1;
        check("b_ready_boundary", 32'(b_ready), 32'd1);
        push_b(10'h001, 1'b1, 10);
        push_b(10'h0BC, 1'b0, 10);
        tick();                       // edge 11 accepts
        b_enb = 1'b0;
        for (int g = 0; g < 40 && exp_b_q.size() != 0; g++) tick();
        mon_b = 1'b0;
        check("b_queue_drained", 32'(exp_b_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serializer_param.md
# serializer_param

Parametrised parallel-to-serial converter for the serdes transmit path. Accepts BITS-wide words over a valid/ready handshake and streams them one bit per clock with a selectable bit order. A one-word holding buffer gives gap-free back-to-back words. When no word is available it fills the slot with a programmable idle/comma word, so the line never stalls.

## Interface
- BITS, 8: word width; legal range 2..32 (10 for 8b/10b symbols).
- MSB_FIRST, 1: 1 = transmit data[BITS-1] first; 0 = transmit data[0] first.
- IDLE_WORD, 8'hBC: word transmitted in empty slots; BITS wide.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- data  in  BITS  parallel word; sampled when enb && ready.
- enb  in  1  word valid; 1 = data holds a valid word.
- ready  out  1  combinational; 1 = a word presented this cycle is accepted at the next edge.
- out  out  1  serial bit, registered.
- DK  out  1  registered; 1 = current out bit belongs to an accepted word, 0 = idle fill.
- sof  out  1  registered; 1 during the first bit of every slot, both data and idle.

## Operation
- Internal state:
  - shifter[BITS-1:0];
  - counter, $clog2(BITS) bits, counting 0..BITS-1;
  - hbuf[BITS-1:0] with flag hvalid;
  - slot type bit, state IDLE or DATA.
- Slot boundary: `last = (counter == BITS-1)`. Each slot is exactly BITS cycles.
- ready = !hvalid || last.
- Source word at a boundary, in priority order:
  - hbuf, if hvalid;
  - otherwise data, if enb (cut-through);
  - otherwise IDLE_WORD.
- At a boundary edge:
  - shifter loads the source word;
  - out gets the source's first bit (per MSB_FIRST);
  - sof <= 1;
  - DK <= 1 if the source is hbuf or data, 0 if idle;
  - state <= DATA or IDLE to match;
  - counter <= 0.
- Buffer update at a boundary edge:
  - hvalid && enb: hbuf <= data, hvalid stays 1;
  - hvalid && !enb: hvalid <= 0;
  - !hvalid && enb: word goes straight to the shifter, hvalid stays 0.
- At a non-boundary edge with counter = k:
  - out <= bit k+1 of the slot word, in transmit order;
  - sof <= 0;
  - DK holds;
  - counter <= k+1.
  - If enb && !hvalid: hbuf <= data, hvalid <= 1.
  - If hvalid: ready is 0 and data is ignored.
- State machine:
  - IDLE -> DATA at a boundary with a word available.
  - DATA -> IDLE at a boundary with none available.
  - Otherwise the state holds.
- Non-power-of-two BITS: counter wraps from BITS-1 to 0, never to 2^n.
- Accepted words are never dropped or reordered. Idle words are never presented on ready.

## Timing
- Reset (asynchronous, immediate):
  - out = 0, DK = 0, sof = 0;
  - hvalid = 0, so ready = 1;
  - shifter = 0, state = IDLE;
  - counter = BITS-1, so the first edge after release is a boundary.
- Reset mid-slot or with a buffered word: all words are discarded and outputs go to 0 in the same cycle, with no clock needed. Restart behaves as above.
- Latency:
  - A word accepted on a boundary edge appears on out on the following cycle (first bit, sof = 1).
  - A word accepted mid-slot waits in hbuf. Its first bit appears the cycle after the next boundary edge.
- Throughput: one word per BITS cycles, sustained, with no idle gap when enb is held with fresh data.
- Simultaneous event at a boundary (hvalid = 1 and enb = 1): hbuf is loaded to the shifter and new data is written to hbuf on the same edge.

## Test plan
- Reset release, enb = 0 (BITS = 8, MSB_FIRST = 1):
  - out repeats 1,0,1,1,1,1,0,0;
  - DK = 0 throughout;
  - sof = 1 every 8th cycle, starting the cycle after the first edge;
  - ready = 1.
- Single word 0xA5 presented on a boundary cycle:
  - next 8 cycles out = 1,0,1,0,0,1,0,1 with DK = 1 and sof on the first bit;
  - then idle 0xBC resumes with DK = 0.
- Words 0x01, 0x80, 0xFF streamed with enb held, advancing on ready:
  - 24 consecutive DK = 1 bits, no idle slot;
  - ready low for 7 of every 8 cycles once hbuf fills.
- 0x3C presented mid-idle-slot at counter = 3:
  - accepted, ready drops to 0 until the boundary;
  - a second word held on data is not accepted early;
  - 0x3C is transmitted in the next slot.
- MSB_FIRST = 0, BITS = 10, word 10'h001:
  - out = 1 followed by nine 0s;
  - sof periodicity is 10 cycles.
- rst pulsed at bit 4 of a data slot with hvalid = 1:
  - out/DK/sof go to 0 asynchronously, ready = 1;
  - the buffered word is never transmitted;
  - an idle slot starts after release.
